// File: rtl/rx_sample_framer_if.sv
// rx_sample_framer_if
// Framed output stream from rx_sample_framer toward the packet router.
//   data     36  {occ[1:0]=0, eof, sof, word[31:0]}
//   src_rdy   1  data valid (source side)
//   dst_rdy   1  sink accepts the word this cycle
// master = framer (drives data/src_rdy), slave = consumer (drives dst_rdy).
interface rx_sample_framer_if;
    logic [35:0] data;
    logic        src_rdy;
    logic        dst_rdy;

    modport master (output data, output src_rdy, input dst_rdy);
    modport slave  (input data, input src_rdy, output dst_rdy);
endinterface

// File: rtl/rx_sample_framer.sv
// rx_sample_framer
// Groups the RX DSP sample stream into frames of up to spp samples, closes
// each frame with a trailer word and buffers whole frames in a FWFT FIFO.
//   clk, rst          clock, synchronous active-high reset
//   set_stb/addr/data settings bus; BASE+0 = spp[15:0], BASE+1 = clear seq
//   sample/strobe/run DSP sample {I,Q}, sample valid, streaming enable
//   out_if            36-bit framed stream (master side)
//   overrun           one-cycle pulse per dropped sample
//   occupied          current FIFO word count
//
// Trailer word: {ovf, eob, 2'b00, seq[11:0], n_samples[15:0]}
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the first sample of a frame
// S_DATA    | frame open, collecting samples until spp, run low or a drop
// S_TRAILER | writing the trailer word, advancing seq
module rx_sample_framer #(
    parameter int BASE      = 176,
    parameter int FIFO_SIZE = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [31:0]          sample,
    input  logic                 strobe,
    input  logic                 run,
    rx_sample_framer_if.master   out_if,
    output logic                 overrun,
    output logic [FIFO_SIZE:0]   occupied
);

    localparam int                 DEPTH     = 1 << FIFO_SIZE;
    // Accepting a sample needs two free entries so the trailer always fits.
    localparam logic [FIFO_SIZE:0] OCC_LIMIT = (FIFO_SIZE+1)'(DEPTH - 2);
    localparam logic [7:0]         ADDR_SPP  = 8'(BASE);
    localparam logic [7:0]         ADDR_SEQ  = 8'(BASE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_TRAILER = 2'd2
    } state_t;

    state_t                 state;
    logic [15:0]            spp;
    logic [15:0]            spp_eff;
    logic [15:0]            frame_spp;
    logic [15:0]            count;
    logic [11:0]            seq;
    logic                   seq_clr;
    logic                   ovf_pend;
    logic                   drop_flag;
    logic                   eob_flag;

    logic [33:0]            mem [DEPTH];
    logic [FIFO_SIZE-1:0]   wr_ptr;
    logic [FIFO_SIZE-1:0]   rd_ptr;
    logic                   not_empty;
    logic                   space_ok;
    logic                   take;
    logic                   wr_en;
    logic [33:0]            wr_word;
    logic                   rd_en;

    // ------------------------------------------------------------------
    // Settings registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            spp     <= '0;
            seq_clr <= 1'b0;
        end else begin
            seq_clr <= set_stb && (set_addr == ADDR_SEQ);
            if (set_stb && (set_addr == ADDR_SPP))
                spp <= set_data[15:0];
        end
    end

    assign spp_eff = (spp == 16'd0) ? 16'd1 : spp;

    // ------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------
    // Free space is judged on registered occupancy, ignoring a same-cycle read.
    assign space_ok  = (occupied <= OCC_LIMIT);
    assign take      = strobe & run;
    assign not_empty = (occupied != '0);
    assign rd_en     = not_empty & out_if.dst_rdy;

    always_comb begin
        wr_en   = 1'b0;
        wr_word = '0;
        case (state)
            S_IDLE: begin
                if (take && space_ok) begin
                    wr_en   = 1'b1;
                    wr_word = {1'b0, 1'b1, sample};
                end
            end
            S_DATA: begin
                if (take && space_ok) begin
                    wr_en   = 1'b1;
                    wr_word = {1'b0, 1'b0, sample};
                end
            end
            S_TRAILER: begin
                wr_en   = 1'b1;
                wr_word = {1'b1, 1'b0, drop_flag | ovf_pend, eob_flag, 2'b00, seq, count};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            frame_spp <= 16'd1;
            seq       <= '0;
            ovf_pend  <= 1'b0;
            drop_flag <= 1'b0;
            eob_flag  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (seq_clr)
                seq <= '0;
            else if (state == S_TRAILER)
                seq <= seq + 12'd1;

            case (state)
                S_IDLE: begin
                    if (take) begin
                        if (space_ok) begin
                            count     <= 16'd1;
                            frame_spp <= spp_eff;
                            // A one-sample frame closes right away.
                            state     <= (spp_eff == 16'd1) ? S_TRAILER : S_DATA;
                        end else begin
                            overrun  <= 1'b1;
                            ovf_pend <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (!run) begin
                        eob_flag <= 1'b1;
                        state    <= S_TRAILER;
                    end else if (strobe) begin
                        if (space_ok) begin
                            count <= count + 16'd1;
                            if (count + 16'd1 == frame_spp)
                                state <= S_TRAILER;
                        end else begin
                            overrun   <= 1'b1;
                            drop_flag <= 1'b1;
                            state     <= S_TRAILER;
                        end
                    end
                end
                S_TRAILER: begin
                    drop_flag <= 1'b0;
                    eob_flag  <= 1'b0;
                    // A strobe landing on the trailer cycle cannot be stored.
                    ovf_pend  <= strobe;
                    overrun   <= strobe;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occupied <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occupied <= occupied + 1'b1;
                2'b01:   occupied <= occupied - 1'b1;
                default: occupied <= occupied;
            endcase
        end
    end

    assign out_if.src_rdy = not_empty;
    assign out_if.data    = not_empty ? {2'b00, mem[rd_ptr]} : 36'd0;

endmodule
